register_arb_m: RTL and testbench



---
 rtl/register_arb_m_if.sv | 32 +++
 rtl/register_arb_m.sv | 106 ++++++++++
 tb/tb_register_arb_m.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/register_arb_m_if.sv
// Bus bundle between the round-robin write arbiter, its requesters and the
// shared register_m instance.
interface register_arb_m_if #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int CNT_W = 8
);
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      rdata;
    logic [WIDTH-1:0]      reg_d;
    logic                  reg_enb;
    logic [WIDTH-1:0]      reg_q;
    logic [IW-1:0]         owner;
    logic                  busy;
    logic [CNT_W-1:0]      xfer_cnt;

    // Environment side: requesters plus the register's q output.
    modport master (
        output req, wdata, reg_q,
        input  gnt, rdata, reg_d, reg_enb, owner, busy, xfer_cnt
    );

    // Arbiter side.
    modport slave (
        input  req, wdata, reg_q,
        output gnt, rdata, reg_d, reg_enb, owner, busy, xfer_cnt
    );
endinterface

// File: rtl/register_arb_m.sv
// Round-robin write arbiter in front of a single register_m. One winner per
// IDLE -> LOAD -> ACK pass; the register is written in LOAD and its new
// contents are returned with the one-hot grant in ACK.
module register_arb_m #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int CNT_W = 8
) (
    input logic             clk,
    input logic             rst,
    register_arb_m_if.slave bus
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, LOAD, ACK} state_t;

    state_t           r_state;
    logic [IW-1:0]    r_ptr;
    logic [IW-1:0]    r_owner;
    logic [WIDTH-1:0] r_reg_d;
    logic [WIDTH-1:0] r_rdata;
    logic [NREQ-1:0]  r_gnt;
    logic             r_reg_enb;
    logic [CNT_W-1:0] r_xfer_cnt;

    logic             w_found;
    logic [IW-1:0]    w_win;
    logic [WIDTH-1:0] w_win_data;

    // (base + k) mod NREQ without relying on NREQ being a power of two.
    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int k);
        int v;
        v = int'(base) + k;
        if (v >= NREQ) v = v - NREQ;
        return IW'(v);
    endfunction

    // Round-robin search starting at r_ptr; first set request bit wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && bus.req[rr_idx(r_ptr, k)]) begin
                w_found = 1'b1;
                w_win   = rr_idx(r_ptr, k);
            end
        end
        w_win_data = bus.wdata[w_win*WIDTH +: WIDTH];
    end

    // Arbiter FSM with all handshake outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_reg_d    <= '0;
            r_rdata    <= '0;
            r_gnt      <= '0;
            r_reg_enb  <= 1'b0;
            r_xfer_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_gnt     <= '0;
                    r_reg_enb <= 1'b0;
                    if (w_found) begin
                        r_owner   <= w_win;
                        r_reg_d   <= w_win_data;
                        r_reg_enb <= 1'b1;
                        r_state   <= LOAD;
                    end
                end
                LOAD: begin
                    // Register captures r_reg_d on this edge; grant shows next.
                    r_reg_enb <= 1'b0;
                    r_gnt     <= NREQ'(1) << r_owner;
                    r_state   <= ACK;
                end
                ACK: begin
                    r_gnt      <= '0;
                    r_rdata    <= bus.reg_q;
                    r_ptr      <= (r_owner == IW'(NREQ-1)) ? '0 : r_owner + IW'(1);
                    r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
                    r_state    <= IDLE;
                end
                default: begin
                    r_gnt     <= '0;
                    r_reg_enb <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    // The register only holds the new value from ACK onward, so rdata shows
    // reg_q live during ACK and a copy taken at the end of ACK otherwise.
    assign bus.rdata    = (r_state == ACK) ? bus.reg_q : r_rdata;
    assign bus.gnt      = r_gnt;
    assign bus.reg_d    = r_reg_d;
    assign bus.reg_enb  = r_reg_enb;
    assign bus.owner    = r_owner;
    assign bus.xfer_cnt = r_xfer_cnt;
    assign bus.busy     = (r_state != IDLE);

endmodule

// File: tb/tb_register_arb_m.sv
// Self-checking bench for register_arb_m: directed vector table, multi-cycle
// corner sequences and randomized traffic against a transaction-level model.
module tb_register_arb_m;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    register_arb_m_if #(.WIDTH(8), .NREQ(4), .CNT_W(8)) bus ();

    register_arb_m #(.WIDTH(8), .NREQ(4), .CNT_W(8)) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    // Stand-in for register_m; its reset is wired to the same rst here.
    always_ff @(posedge clk) begin
        if (rst)              bus.reg_q <= 8'h00;
        else if (bus.reg_enb) bus.reg_q <= bus.reg_d;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: phase 0 = waiting, 1 = write cycle, 2 = grant cycle.
    int         m_phase = 0;
    logic [1:0] m_ptr = 0, m_owner = 0;
    logic [7:0] m_regd = 0, m_hold = 0, m_q = 0, m_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge();
        int  i;
        bit  found;
        if (rst) m_q = 8'h00;
        else if (m_phase == 1) m_q = m_regd;
        if (rst) begin
            m_phase = 0; m_ptr = 0; m_owner = 0; m_regd = 0; m_hold = 0; m_cnt = 0;
        end else if (m_phase == 0) begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
                i = (int'(m_ptr) + k) % 4;
                if (!found && bus.req[i]) begin
                    found   = 1;
                    m_owner = 2'(i);
                    m_regd  = bus.wdata[i*8 +: 8];
                end
            end
            if (found) m_phase = 1;
        end else if (m_phase == 1) begin
            m_phase = 2;
        end else begin
            m_cnt   = m_cnt + 8'd1;
            m_ptr   = 2'((int'(m_owner) + 1) % 4);
            m_hold  = m_q;
            m_phase = 0;
        end
    endtask

    // One clock: advance the model at the edge, compare at the falling edge.
    task automatic step();
        logic [3:0] one;
        logic [3:0] eg;
        one = 4'b0001;
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        eg = (m_phase == 2) ? (one << m_owner) : 4'b0000;
        check("gnt",   32'(bus.gnt),      32'(eg));
        check("enb",   32'(bus.reg_enb),  32'(m_phase == 1));
        check("reg_d", 32'(bus.reg_d),    32'(m_regd));
        check("rdata", 32'(bus.rdata),    32'((m_phase == 2) ? m_q : m_hold));
        check("owner", 32'(bus.owner),    32'(m_owner));
        check("busy",  32'(bus.busy),     32'(m_phase != 0));
        check("cnt",   32'(bus.xfer_cnt), 32'(m_cnt));
    endtask

    task automatic wait_grant(output logic [3:0] g);
        g = 4'b0000;
        for (int n = 0; n < 20; n++) begin
            step();
            if (bus.gnt != 4'b0000) begin
                g = bus.gnt;
                return;
            end
        end
        check("grant_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req = 4'b1111;
        step();
        step();
        check("rst_gnt",   32'(bus.gnt),      32'h0);
        check("rst_enb",   32'(bus.reg_enb),  32'h0);
        check("rst_reg_d", 32'(bus.reg_d),    32'h0);
        check("rst_rdata", 32'(bus.rdata),    32'h0);
        check("rst_cnt",   32'(bus.xfer_cnt), 32'h0);
        check("rst_busy",  32'(bus.busy),     32'h0);
        rst = 1'b0;
        bus.req = 4'b0000;
    endtask

    typedef struct {
        logic [3:0]  req;
        logic [31:0] wdata;
        logic [3:0]  exp_gnt;
        logic [7:0]  exp_rdata;
        logic [1:0]  exp_owner;
    } vec_t;

    initial begin
        vec_t       vecs[5];
        logic [3:0] g;
        logic [3:0] seen[$];
        int         tg[4];
        logic [7:0] last_d;
        logic [3:0] one;
        int         r;

        one = 4'b0001;
        // Each vector starts from the pointer left by the previous one.
        vecs[0] = '{4'b0001, 32'h000000AA, 4'b0001, 8'hAA, 2'd0};
        vecs[1] = '{4'b0100, 32'h00770000, 4'b0100, 8'h77, 2'd2};
        vecs[2] = '{4'b1010, 32'h99001100, 4'b1000, 8'h99, 2'd3};
        vecs[3] = '{4'b0110, 32'h00E74200, 4'b0010, 8'h42, 2'd1};
        vecs[4] = '{4'b1111, 32'h10E73355, 4'b0100, 8'hE7, 2'd2};

        bus.req   = 4'b1111;
        bus.wdata = 32'h0;
        do_reset();

        // Directed table: hold request until granted, then drop it.
        foreach (vecs[i]) begin
            bus.req   = vecs[i].req;
            bus.wdata = vecs[i].wdata;
            wait_grant(g);
            check("vec_gnt",   32'(g),         32'(vecs[i].exp_gnt));
            check("vec_rdata", 32'(bus.rdata), 32'(vecs[i].exp_rdata));
            check("vec_owner", 32'(bus.owner), 32'(vecs[i].exp_owner));
            bus.req = 4'b0000;
            step();
            check("vec_cnt", 32'(bus.xfer_cnt), 32'(i + 1));
        end

        // All four requesters at once, each leaving after its own grant.
        do_reset();
        bus.req   = 4'b1111;
        bus.wdata = 32'h44332211;
        for (int i = 0; i < 4; i++) begin
            wait_grant(g);
            tg[i] = cyc;
            check("all_gnt",   32'(g),         32'(one << i));
            check("all_rdata", 32'(bus.rdata), 32'(8'h11 * (i + 1)));
            if (i > 0) check("all_spacing", 32'(tg[i] - tg[i-1]), 32'd3);
            bus.req = bus.req & ~g;
        end
        step();
        check("all_cnt", 32'(bus.xfer_cnt), 32'd4);

        // Fairness: two requesters held continuously for 12 cycles.
        do_reset();
        bus.req   = 4'b0011;
        bus.wdata = 32'h0000BBAA;
        for (int n = 0; n < 12; n++) begin
            step();
            if (bus.gnt != 4'b0000) seen.push_back(bus.gnt);
        end
        check("fair_count", 32'(seen.size()), 32'd4);
        for (int i = 0; i < seen.size() && i < 4; i++)
            check("fair_order", 32'(seen[i]), (i % 2 == 0) ? 32'h1 : 32'h2);
        bus.req = 4'b0000;
        step();
        step();

        // Reset landing on the write cycle of requester 2.
        do_reset();
        bus.req   = 4'b0100;
        bus.wdata = 32'h005A0000;
        for (int n = 0; n < 10 && !bus.reg_enb; n++) step();
        check("mid_in_load", 32'(bus.reg_enb), 32'd1);
        rst = 1'b1;
        bus.req = 4'b0000;
        step();
        rst = 1'b0;
        for (int n = 0; n < 4; n++) begin
            step();
            check("mid_no_gnt", 32'(bus.gnt), 32'h0);
        end
        check("mid_cnt", 32'(bus.xfer_cnt), 32'h0);
        bus.req   = 4'b0010;
        bus.wdata = 32'h00003C00;
        wait_grant(g);
        check("mid_gnt",   32'(g),         32'h2);
        check("mid_rdata", 32'(bus.rdata), 32'h3C);
        bus.req = 4'b0000;
        step();

        // 256 back-to-back single writes: counter must wrap to zero.
        do_reset();
        last_d = 8'h00;
        for (int n = 0; n < 256; n++) begin
            r         = $urandom_range(0, 3);
            last_d    = 8'($urandom);
            bus.wdata = 32'($urandom);
            bus.wdata[r*8 +: 8] = last_d;
            bus.req   = one << r;
            wait_grant(g);
            check("wrap_gnt", 32'(g), 32'(one << r));
            bus.req = 4'b0000;
        end
        step();
        check("wrap_cnt",   32'(bus.xfer_cnt), 32'h0);
        check("wrap_rdata", 32'(bus.rdata),    32'(last_d));

        // Random traffic with occasional resets against the model.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            bus.req   = 4'($urandom);
            bus.wdata = $urandom;
            rst       = ($urandom_range(0, 49) == 0);
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
